mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM and MEM/WB pipeline registers.
//  Drives the data-memory request/ack handshake for loads and stores.
//  Generates byte enables and aligned store data, and sign/zero-extends load data.
//  Holds the pipeline through stallreq_mem until each access completes or times out.
// PARAMETERS
//  MAX_WAIT  255  cycles in WAIT without dm_ack before the access is aborted with bus_err
//  CNT_W     8    width of the wait counter; must satisfy 2**CNT_W > MAX_WAIT
// PORTS
//  clk             in   1   clock, rising edge
//  rstn            in   1   asynchronous reset, active-low
//  flush           in   1   squash the current MEM instruction
//  mem_pc          in   32  PC of the MEM instruction
//  mem_func3       in   3   load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_rd          in   5   destination register
//  mem_wreg        in   1   instruction writes rd
//  mem_alu_res     in   32  ALU result; this is the effective address for loads/stores
//  mem_store_data  in   32  rs2 value for stores
//  mem_memrd       in   1   load
//  mem_memwr       in   1   store
//  mem_mem2reg     in   1   rd is written from memory data
//  dm_req          out  1   access request, level-held until ack
//  dm_addr         out  32  word address: {mem_alu_res[31:2],2'b00}
//  dm_web          out  4   byte write enables, active-high; 0000 for loads
//  dm_wdata        out  32  store data shifted into byte lanes
//  dm_rdata        in   32  read data, valid with dm_ack
//  dm_ack          in   1   access complete
//  stallreq_mem    out  1   stall request to the hazard/stall controller
//  wb_pc           out  32  passed to MEM/WB
//  wb_rd           out  5   passed to MEM/WB
//  wb_wreg         out  1   writeback enable, after squashing
//  wb_wdata        out  32  load data (extended) or mem_alu_res
//  misalign        out  1   misaligned access detected
//  bus_err         out  1   access timed out
// BEHAVIOUR
//  FSM states: IDLE, WAIT, DONE. Reset values:
//   - state=IDLE, wait cnt=0, rdata_q=0, err_q=0, flushed_q=0
//   - dm_req=0, stallreq_mem=0
//   - all other outputs follow their (zero) inputs
//  op = (mem_memrd|mem_memwr) & ~flush & ~misalign.
//  misalign is combinational:
//   - H or HU with addr[0]=1
//   - W with addr[1:0]!=0
//   - B and BU never misalign
//  When misalign=1: no request is issued and wb_wreg is forced to 0.
//  IDLE:
//   - If op: dm_req=1 and stallreq_mem=1.
//   - dm_ack in the same cycle: capture rdata_q and go to DONE.
//   - Otherwise go to WAIT.
//  WAIT:
//   - dm_req=1 and stallreq_mem=1; addr, web and wdata are held stable.
//   - The counter increments every cycle.
//   - On dm_ack: capture rdata_q and go to DONE.
//   - If the counter reaches MAX_WAIT first: set err_q and go to DONE. A later ack is ignored.
//  DONE:
//   - dm_req=0 and stallreq_mem=0.
//   - Outputs are built from rdata_q; bus_err=err_q.
//   - Next cycle: IDLE, with cnt, err_q and flushed_q cleared. The register feeding this stage advances during DONE, so no access is reissued.
//  Non-memory instruction: pure pass-through with zero added latency.
//   - wb_wdata=mem_alu_res; wb_wreg=mem_wreg & ~flush.
//  Store lanes by addr[1:0]:
//   - SB: web=0001<<a; wdata=data[7:0] replicated x4
//   - SH: web=0011<<a; wdata=data[15:0] replicated x2
//   - SW: web=1111; wdata=data
//  Load select by addr[1:0]: byte rdata_q[8a+7:8a], half rdata_q[16a[1]+15:16a[1]].
//   - B/H sign-extend; BU/HU zero-extend.
//  Flush in IDLE: no request is issued and wb_wreg=0.
//  Flush in WAIT: the access cannot be cancelled. Set flushed_q, wait for ack or timeout, then DONE with wb_wreg=0.
//  bus_err in DONE forces wb_wreg=0 and wb_wdata=0.
//  Stores never assert wb_wreg, regardless of mem_wreg.
//  rstn low mid-access: the FSM returns to IDLE immediately and dm_req drops asynchronously.
// TESTING
//  Non-memory instr, alu_res=0x1234: wb_wdata=0x1234 the same cycle; stallreq_mem never asserted.
//  LB addr=0x103, dm_rdata=0x80xxxxxx, ack after 3 cycles: stall held 4 cycles, then wb_wdata=0xFFFFFF80.
//  SH addr=0x102, data=0xABCD: dm_web=1100, dm_wdata=0xABCDABCD, wb_wreg=0.
//  LW addr=0x101: misalign=1, dm_req=0, wb_wreg=0, no stall.
//  LW, flush asserted in WAIT, ack 2 cycles later: DONE with wb_wreg=0.
//  LW, no ack for MAX_WAIT cycles: bus_err=1 in DONE, wb_wreg=0; a late ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: RV32I MEM stage. Drives the data-memory req/ack handshake,
// builds byte lanes for stores, extends load data and stalls the pipeline
// until each access completes or times out.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [31:0] mem_pc,
    input  logic [2:0]  mem_func3,
    input  logic [4:0]  mem_rd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_store_data,
    input  logic        mem_memrd,
    input  logic        mem_memwr,
    input  logic        mem_mem2reg,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_web,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stallreq_mem,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic              flushed_q;
    logic [XLEN-1:0]   addr_q;
    logic [3:0]        web_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        f3_q;
    logic              ld_q;
    logic              m2r_q;

    logic              is_mem_c;
    logic              misalign_c;
    logic              op_c;
    logic [3:0]        web_c;
    logic [XLEN-1:0]   wdata_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic [XLEN-1:0]   ld_ext_c;

    assign is_mem_c = mem_memrd | mem_memwr;
    assign op_c     = is_mem_c & ~flush & ~misalign_c;
    assign misalign = misalign_c;
    assign wb_pc    = mem_pc;
    assign wb_rd    = mem_rd;

    // Alignment check: halves need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        misalign_c = 1'b0;
        if (is_mem_c) begin
            case (mem_func3[1:0])
                2'b00:   misalign_c = 1'b0;
                2'b01:   misalign_c = mem_alu_res[0];
                default: misalign_c = |mem_alu_res[1:0];
            endcase
        end
    end

    // Store byte-lane steering and write enables
    always_comb begin
        web_c   = 4'b0000;
        wdata_c = mem_store_data;
        case (mem_func3[1:0])
            2'b00: begin
                web_c   = 4'b0001 << mem_alu_res[1:0];
                wdata_c = {4{mem_store_data[7:0]}};
            end
            2'b01: begin
                web_c   = 4'b0011 << mem_alu_res[1:0];
                wdata_c = {2{mem_store_data[15:0]}};
            end
            default: begin
                web_c   = 4'b1111;
                wdata_c = mem_store_data;
            end
        endcase
        if (!mem_memwr) begin
            web_c = 4'b0000;
        end
    end

    // Load lane select and sign/zero extension from the captured read data
    always_comb begin
        ld_byte_c = rdata_q[{addr_q[1:0], 3'b000} +: 8];
        ld_half_c = rdata_q[{addr_q[1], 4'b0000} +: 16];
        ld_ext_c  = rdata_q;
        case (f3_q[1:0])
            2'b00:   ld_ext_c = f3_q[2] ? {24'd0, ld_byte_c}
                                        : {{24{ld_byte_c[7]}}, ld_byte_c};
            2'b01:   ld_ext_c = f3_q[2] ? {16'd0, ld_half_c}
                                        : {{16{ld_half_c[15]}}, ld_half_c};
            default: ld_ext_c = rdata_q;
        endcase
    end

    // Access FSM: capture the request, wait for ack or timeout, present result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
            addr_q    <= '0;
            web_q     <= 4'b0000;
            wdata_q   <= '0;
            f3_q      <= 3'b000;
            ld_q      <= 1'b0;
            m2r_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_c) begin
                        addr_q  <= mem_alu_res;
                        web_q   <= web_c;
                        wdata_q <= wdata_c;
                        f3_q    <= mem_func3;
                        ld_q    <= mem_memrd & ~mem_memwr;
                        m2r_q   <= mem_mem2reg & mem_memrd & ~mem_memwr;
                        cnt_q   <= '0;
                        if (dm_ack) begin
                            rdata_q <= dm_rdata;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (dm_ack) begin
                        rdata_q <= dm_rdata;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    err_q     <= 1'b0;
                    flushed_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Handshake and writeback outputs; non-memory ops pass straight through
    always_comb begin
        dm_req       = 1'b0;
        stallreq_mem = 1'b0;
        dm_addr      = {mem_alu_res[31:2], 2'b00};
        dm_web       = 4'b0000;
        dm_wdata     = wdata_c;
        wb_wdata     = mem_alu_res;
        wb_wreg      = mem_wreg & ~flush & ~is_mem_c;
        bus_err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                dm_req       = op_c;
                stallreq_mem = op_c;
                if (op_c) begin
                    dm_web = web_c;
                end
            end
            S_WAIT: begin
                dm_req       = 1'b1;
                stallreq_mem = 1'b1;
                dm_addr      = {addr_q[31:2], 2'b00};
                dm_web       = web_q;
                dm_wdata     = wdata_q;
            end
            S_DONE: begin
                bus_err = err_q;
                wb_wreg = ld_q & mem_wreg & ~flush & ~flushed_q & ~err_q;
                if (err_q) begin
                    wb_wdata = '0;
                end else if (m2r_q) begin
                    wb_wdata = ld_ext_c;
                end
            end
            default: ;
        endcase
        // Request and stall drop as soon as reset is applied
        if (!rstn) begin
            dm_req       = 1'b0;
            stallreq_mem = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// tb_mem_stage: directed vectors for the MEM stage with hand-computed results.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [31:0] mem_pc;
    logic [2:0]  mem_func3;
    logic [4:0]  mem_rd;
    logic        mem_wreg;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_store_data;
    logic        mem_memrd;
    logic        mem_memwr;
    logic        mem_mem2reg;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_web;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stallreq_mem;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        misalign;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .mem_pc         (mem_pc),
        .mem_func3      (mem_func3),
        .mem_rd         (mem_rd),
        .mem_wreg       (mem_wreg),
        .mem_alu_res    (mem_alu_res),
        .mem_store_data (mem_store_data),
        .mem_memrd      (mem_memrd),
        .mem_memwr      (mem_memwr),
        .mem_mem2reg    (mem_mem2reg),
        .dm_req         (dm_req),
        .dm_addr        (dm_addr),
        .dm_web         (dm_web),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .dm_ack         (dm_ack),
        .stallreq_mem   (stallreq_mem),
        .wb_pc          (wb_pc),
        .wb_rd          (wb_rd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .misalign       (misalign),
        .bus_err        (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        flush          = 1'b0;
        mem_pc         = 32'h0;
        mem_func3      = 3'b000;
        mem_rd         = 5'd0;
        mem_wreg       = 1'b0;
        mem_alu_res    = 32'h0;
        mem_store_data = 32'h0;
        mem_memrd      = 1'b0;
        mem_memwr      = 1'b0;
        mem_mem2reg    = 1'b0;
        dm_ack         = 1'b0;
        dm_rdata       = 32'h0;
    endtask

    task automatic set_load(input logic [2:0] f3, input logic [31:0] addr);
        set_nop();
        mem_func3   = f3;
        mem_alu_res = addr;
        mem_rd      = 5'd7;
        mem_wreg    = 1'b1;
        mem_memrd   = 1'b1;
        mem_mem2reg = 1'b1;
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        set_nop();
        mem_func3      = f3;
        mem_alu_res    = addr;
        mem_store_data = data;
        mem_wreg       = 1'b1;
        mem_memwr      = 1'b1;
    endtask

    // Load acked in its request cycle; result checked in the following cycle
    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [31:0] exp);
        tick();
        set_load(f3, addr);
        dm_ack   = 1'b1;
        dm_rdata = rdata;
        @(negedge clk);
        check({tag, "_stall"}, 32'(stallreq_mem), 32'd1);
        tick();
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        @(negedge clk);
        check({tag, "_data"}, wb_wdata, exp);
        check({tag, "_wreg"}, 32'(wb_wreg), 32'd1);
        tick();
        set_nop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        set_nop();
        rstn = 1'b0;
        #12;
        check("rst_req",   32'(dm_req),       32'd0);
        check("rst_stall", 32'(stallreq_mem), 32'd0);
        check("rst_wdata", wb_wdata,          32'h0);
        check("rst_err",   32'(bus_err),      32'd0);
        rstn = 1'b1;

        // Non-memory pass-through
        tick();
        mem_alu_res = 32'h1234;
        mem_wreg    = 1'b1;
        mem_rd      = 5'd5;
        mem_pc      = 32'h80;
        @(negedge clk);
        check("alu_wdata", wb_wdata,          32'h1234);
        check("alu_wreg",  32'(wb_wreg),      32'd1);
        check("alu_stall", 32'(stallreq_mem), 32'd0);
        check("alu_req",   32'(dm_req),       32'd0);
        check("alu_rd",    32'(wb_rd),        32'd5);
        check("alu_pc",    wb_pc,             32'h80);
        flush = 1'b1;
        #1;
        check("alu_flush_wreg", 32'(wb_wreg), 32'd0);

        // LB 0x103, ack on the fourth stalled cycle
        tick();
        set_load(3'b000, 32'h103);
        @(negedge clk);
        check("lb_stall0",  32'(stallreq_mem), 32'd1);
        check("lb_req0",    32'(dm_req),       32'd1);
        check("lb_addr",    dm_addr,           32'h100);
        check("lb_web",     32'(dm_web),       32'd0);
        check("lb_misal",   32'(misalign),     32'd0);
        check("lb_wreg0",   32'(wb_wreg),      32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 3) begin
                dm_ack   = 1'b1;
                dm_rdata = 32'h80123456;
            end
            @(negedge clk);
            check("lb_stall", 32'(stallreq_mem), 32'd1);
            check("lb_addr_hold", dm_addr, 32'h100);
        end
        tick();
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        @(negedge clk);
        check("lb_done_stall", 32'(stallreq_mem), 32'd0);
        check("lb_done_req",   32'(dm_req),       32'd0);
        check("lb_data",       wb_wdata,          32'hFFFFFF80);
        check("lb_wreg",       32'(wb_wreg),      32'd1);
        tick();
        set_nop();

        // SH 0x102 acked immediately
        tick();
        set_store(3'b001, 32'h102, 32'h0000ABCD);
        dm_ack = 1'b1;
        @(negedge clk);
        check("sh_web",   32'(dm_web),  32'hC);
        check("sh_wdata", dm_wdata,     32'hABCDABCD);
        check("sh_req",   32'(dm_req),  32'd1);
        check("sh_wreg",  32'(wb_wreg), 32'd0);
        tick();
        dm_ack = 1'b0;
        @(negedge clk);
        check("sh_done_stall", 32'(stallreq_mem), 32'd0);
        check("sh_done_wreg",  32'(wb_wreg),      32'd0);
        tick();
        set_nop();

        // SB 0x101 acked immediately
        tick();
        set_store(3'b000, 32'h101, 32'h12345678);
        dm_ack = 1'b1;
        @(negedge clk);
        check("sb_web",   32'(dm_web), 32'h2);
        check("sb_wdata", dm_wdata,    32'h78787878);
        tick();
        set_nop();
        tick();

        // Load extensions
        quick_load("lh",  3'b001, 32'h102, 32'hBEEF1234, 32'hFFFFBEEF);
        quick_load("lhu", 3'b101, 32'h102, 32'hBEEF1234, 32'h0000BEEF);
        quick_load("lbu", 3'b100, 32'h101, 32'h00008000, 32'h00000080);
        quick_load("lw",  3'b010, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);

        // Misaligned accesses
        tick();
        set_load(3'b010, 32'h101);
        @(negedge clk);
        check("lw_mis",       32'(misalign),     32'd1);
        check("lw_mis_req",   32'(dm_req),       32'd0);
        check("lw_mis_stall", 32'(stallreq_mem), 32'd0);
        check("lw_mis_wreg",  32'(wb_wreg),      32'd0);
        tick();
        set_load(3'b001, 32'h103);
        @(negedge clk);
        check("lh_mis",     32'(misalign), 32'd1);
        check("lh_mis_req", 32'(dm_req),   32'd0);

        // Flush in IDLE: no request
        tick();
        set_load(3'b010, 32'h200);
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_req",  32'(dm_req),  32'd0);
        check("flush_idle_wreg", 32'(wb_wreg), 32'd0);

        // Flush during WAIT: access completes, writeback squashed
        tick();
        set_load(3'b010, 32'h200);
        @(negedge clk);
        check("fw_stall0", 32'(stallreq_mem), 32'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("fw_req_flush", 32'(dm_req), 32'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fw_stall2", 32'(stallreq_mem), 32'd1);
        tick();
        dm_ack   = 1'b1;
        dm_rdata = 32'h11223344;
        @(negedge clk);
        check("fw_stall3", 32'(stallreq_mem), 32'd1);
        tick();
        dm_ack = 1'b0;
        @(negedge clk);
        check("fw_done_stall", 32'(stallreq_mem), 32'd0);
        check("fw_done_wreg",  32'(wb_wreg),      32'd0);
        tick();
        set_nop();

        // Timeout: 1 IDLE + 255 WAIT cycles of stall, then bus_err
        tick();
        set_load(3'b010, 32'h300);
        @(negedge clk);
        cyc = 0;
        while (stallreq_mem === 1'b1 && cyc < 400) begin
            cyc++;
            tick();
            @(negedge clk);
        end
        check("to_cycles", 32'(cyc), 32'd256);
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEADBEEF;
        #1;
        check("to_err",   32'(bus_err), 32'd1);
        check("to_wreg",  32'(wb_wreg), 32'd0);
        check("to_wdata", wb_wdata,     32'h0);
        check("to_req",   32'(dm_req),  32'd0);
        tick();
        set_nop();
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("to_after_err",   32'(bus_err),      32'd0);
        check("to_after_stall", 32'(stallreq_mem), 32'd0);
        tick();
        dm_ack = 1'b0;

        // Reset mid-access drops the request at once
        tick();
        set_load(3'b010, 32'h400);
        tick();
        @(negedge clk);
        check("rst_mid_req1", 32'(dm_req), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_req",   32'(dm_req),       32'd0);
        check("rst_mid_stall", 32'(stallreq_mem), 32'd0);
        set_nop();
        tick();
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_after_stall", 32'(stallreq_mem), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
